dyn_phase_shift: RTL and testbench

Multi-channel, counter-based phase-shift and duty-cycle generator for the PLL/MMCM simulation model. It sits after the VCO stage and derives CHANNELS output clocks from the VCO-rate tick clock. Each channel has its own divide, high time and static phase, all in VCO ticks. A per-channel dynamic phase adjust uses an MMCM-style en/incdec/done handshake. Shared lock and power-down behaviour match the existing phase-shift model.

---
 rtl/dyn_phase_shift_pkg.sv | 34 +++
 rtl/dyn_phase_shift_channel.sv | 84 ++++++++
 rtl/dyn_phase_shift.sv | 148 ++++++++++++++
 tb/tb_dyn_phase_shift.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_phase_shift_pkg.sv
// Shared types, default parameters and modular-count helpers for the
// dynamic phase-shift clock generator.
package dyn_phase_shift_pkg;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_CNT_WIDTH    = 8;
    localparam int DEF_PSDONE_DELAY = 12;
    localparam int DEF_LOCK_DELAY   = 64;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_BUSY = 1'b1
    } ps_state_e;

    // Channel-select width; a single channel still gets a one-bit select.
    function automatic int sel_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Step forward within 0..d-1, wrapping at d-1.
    function automatic logic [31:0] mod_inc(input logic [31:0] v, input logic [31:0] d);
        return (v == d - 32'd1) ? 32'd0 : v + 32'd1;
    endfunction

    // Step backward within 0..d-1, wrapping at 0.
    function automatic logic [31:0] mod_dec(input logic [31:0] v, input logic [31:0] d);
        return (v == 32'd0) ? d - 32'd1 : v - 32'd1;
    endfunction

endpackage

// File: rtl/dyn_phase_shift_channel.sv
// One output clock: free-running mod-D tick counter, dynamic offset register
// and the phase/duty compare feeding a registered output.
module phase_shift_channel
    import dyn_phase_shift_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pwrdwn_i,
    input  logic                 restart_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    input  logic [CNT_WIDTH-1:0] divide_i,
    input  logic [CNT_WIDTH-1:0] high_i,
    input  logic [CNT_WIDTH-1:0] phase_i,
    output logic                 clk_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] off_q;
    logic [CNT_WIDTH-1:0] off_d;
    logic                 clk_q;

    logic [CNT_WIDTH-1:0] div_s;
    logic [CNT_WIDTH-1:0] dm1_s;
    logic [CNT_WIDTH-1:0] ph_s;
    logic [CNT_WIDTH:0]   sum_s;
    logic [CNT_WIDTH:0]   wrap_s;
    logic [CNT_WIDTH-1:0] eff_s;
    logic [CNT_WIDTH-1:0] pos_s;
    logic                 high_s;

    assign div_s = (divide_i < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : divide_i;
    assign dm1_s = div_s - CNT_WIDTH'(1);
    assign ph_s  = (phase_i > dm1_s) ? dm1_s : phase_i;

    // Static phase plus offset, folded back into one period; both terms are < D.
    assign sum_s  = {1'b0, ph_s} + {1'b0, off_q};
    assign wrap_s = (sum_s >= {1'b0, div_s}) ? (sum_s - {1'b0, div_s}) : sum_s;
    assign eff_s  = wrap_s[CNT_WIDTH-1:0];

    // The low-side branch may overflow intermediately; the true result is < D so it wraps back.
    assign pos_s  = (cnt_q >= eff_s) ? (cnt_q - eff_s) : (cnt_q + div_s - eff_s);
    assign high_s = (pos_s < high_i);

    assign cnt_d = CNT_WIDTH'(mod_inc(32'(cnt_q), 32'(div_s)));

    // Next offset from the one-cycle inc/dec strobes.
    always_comb begin
        off_d = off_q;
        if (inc_i) begin
            off_d = CNT_WIDTH'(mod_inc(32'(off_q), 32'(div_s)));
        end else if (dec_i) begin
            off_d = CNT_WIDTH'(mod_dec(32'(off_q), 32'(div_s)));
        end else begin
            off_d = off_q;
        end
    end

    // Counter, offset and output register; a divide change restarts the channel cleanly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
            off_q <= {CNT_WIDTH{1'b0}};
            clk_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
            off_q <= {CNT_WIDTH{1'b0}};
            clk_q <= 1'b0;
        end else if (pwrdwn_i) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            off_q <= off_d;
            clk_q <= high_s;
        end
    end

    assign clk_o = clk_q;

endmodule

// File: rtl/dyn_phase_shift.sv
// Multi-channel phase-shift / duty-cycle generator with an en/incdec/done
// dynamic phase handshake and a shared config-stability lock.
module dyn_phase_shift
    import dyn_phase_shift_pkg::*;
#(
    parameter  int CHANNELS     = DEF_CHANNELS,
    parameter  int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter  int PSDONE_DELAY = DEF_PSDONE_DELAY,
    parameter  int LOCK_DELAY   = DEF_LOCK_DELAY,
    localparam int SEL_W        = sel_width(CHANNELS),
    localparam int CFG_W        = CHANNELS * CNT_WIDTH
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                PWRDWN,
    input  logic [CFG_W-1:0]    divide,
    input  logic [CFG_W-1:0]    high_cnt,
    input  logic [CFG_W-1:0]    phase_cnt,
    input  logic                ps_en,
    input  logic                ps_incdec,
    input  logic [SEL_W-1:0]    ps_sel,
    output logic                ps_done,
    output logic [CHANNELS-1:0] clk_out,
    output logic                lock
);

    localparam int DLY_W = $clog2(PSDONE_DELAY);
    localparam int LCK_W = $clog2(LOCK_DELAY + 1);

    ps_state_e          ps_state_q;
    logic [DLY_W-1:0]   dly_q;
    logic               ps_done_q;
    logic               accept_s;

    logic [CFG_W-1:0]   div_sh_q;
    logic [CFG_W-1:0]   high_sh_q;
    logic [CFG_W-1:0]   phase_sh_q;
    logic               sh_vld_q;
    logic               cfg_chg_s;
    logic [CHANNELS-1:0] div_chg_s;

    logic [LCK_W-1:0]   lock_cnt_q;
    logic [LCK_W-1:0]   lock_cnt_d;
    logic               lock_q;

    assign accept_s = (ps_state_q == PS_IDLE) && ps_en && !PWRDWN;

    // Handshake FSM: accept in IDLE, count down, pulse done while returning to IDLE.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ps_state_q <= PS_IDLE;
            dly_q      <= {DLY_W{1'b0}};
            ps_done_q  <= 1'b0;
        end else if (PWRDWN) begin
            ps_state_q <= PS_IDLE;
            dly_q      <= {DLY_W{1'b0}};
            ps_done_q  <= 1'b0;
        end else begin
            case (ps_state_q)
                PS_IDLE: begin
                    ps_done_q <= 1'b0;
                    if (ps_en) begin
                        ps_state_q <= PS_BUSY;
                        dly_q      <= DLY_W'(PSDONE_DELAY - 1);
                    end else begin
                        ps_state_q <= PS_IDLE;
                    end
                end
                PS_BUSY: begin
                    if (dly_q == {DLY_W{1'b0}}) begin
                        ps_state_q <= PS_IDLE;
                        ps_done_q  <= 1'b1;
                    end else begin
                        dly_q     <= dly_q - DLY_W'(1);
                        ps_done_q <= 1'b0;
                    end
                end
                default: begin
                    ps_state_q <= PS_IDLE;
                    dly_q      <= {DLY_W{1'b0}};
                    ps_done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow copy of the configuration; the first edge after reset only loads it.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            div_sh_q   <= {CFG_W{1'b0}};
            high_sh_q  <= {CFG_W{1'b0}};
            phase_sh_q <= {CFG_W{1'b0}};
            sh_vld_q   <= 1'b0;
        end else begin
            div_sh_q   <= divide;
            high_sh_q  <= high_cnt;
            phase_sh_q <= phase_cnt;
            sh_vld_q   <= 1'b1;
        end
    end

    assign cfg_chg_s = sh_vld_q && ((divide != div_sh_q) || (high_cnt != high_sh_q) ||
                                    (phase_cnt != phase_sh_q));

    assign lock_cnt_d = (lock_cnt_q == LCK_W'(LOCK_DELAY)) ? lock_cnt_q : lock_cnt_q + LCK_W'(1);

    // Lock counter: any config change or power-down restarts the stability window.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            lock_cnt_q <= {LCK_W{1'b0}};
            lock_q     <= 1'b0;
        end else if (PWRDWN || cfg_chg_s) begin
            lock_cnt_q <= {LCK_W{1'b0}};
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= (lock_cnt_d == LCK_W'(LOCK_DELAY));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic hit_s;

        assign div_chg_s[g] = sh_vld_q &&
            (divide[g*CNT_WIDTH +: CNT_WIDTH] != div_sh_q[g*CNT_WIDTH +: CNT_WIDTH]);
        // Out-of-range selects match no channel, so the request only produces ps_done.
        assign hit_s = accept_s && (ps_sel == SEL_W'(g));

        phase_shift_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (RST),
            .pwrdwn_i  (PWRDWN),
            .restart_i (div_chg_s[g]),
            .inc_i     (hit_s && ps_incdec),
            .dec_i     (hit_s && !ps_incdec),
            .divide_i  (divide[g*CNT_WIDTH +: CNT_WIDTH]),
            .high_i    (high_cnt[g*CNT_WIDTH +: CNT_WIDTH]),
            .phase_i   (phase_cnt[g*CNT_WIDTH +: CNT_WIDTH]),
            .clk_o     (clk_out[g])
        );
    end

    assign ps_done = ps_done_q;
    assign lock    = lock_q;

endmodule

// File: tb/tb_dyn_phase_shift.sv
// Directed bench for dyn_phase_shift: table of static waveform vectors plus
// hand sequences for the handshake, lock, config-change and power-down cases.
module tb_dyn_phase_shift;

    localparam int CH = 5;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            RST = 1'b1;
    logic            PWRDWN = 1'b0;
    logic [CH*W-1:0] divide;
    logic [CH*W-1:0] high_cnt;
    logic [CH*W-1:0] phase_cnt;
    logic            ps_en = 1'b0;
    logic            ps_incdec = 1'b0;
    logic [2:0]      ps_sel = 3'd0;
    logic            ps_done;
    logic [CH-1:0]   clk_out;
    logic            lock;

    int checks = 0;
    int errors = 0;
    int e = 0;
    int done_cnt = 0;
    int cfg_d[CH];
    int cfg_h[CH];
    int cfg_p[CH];
    int off_exp;
    int lat;
    int d0;
    int bad;
    logic [15:0] w;

    typedef struct {
        string       name;
        int          ch;
        int          d;
        int          h;
        int          p;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[11];

    dyn_phase_shift #(
        .CHANNELS     (CH),
        .CNT_WIDTH    (W),
        .PSDONE_DELAY (12),
        .LOCK_DELAY   (64)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .PWRDWN    (PWRDWN),
        .divide    (divide),
        .high_cnt  (high_cnt),
        .phase_cnt (phase_cnt),
        .ps_en     (ps_en),
        .ps_incdec (ps_incdec),
        .ps_sel    (ps_sel),
        .ps_done   (ps_done),
        .clk_out   (clk_out),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    // Edges since the last reset or power-down edge.
    always @(posedge clk or posedge RST) begin
        if (RST) e <= 0;
        else if (PWRDWN) e <= 0;
        else e <= e + 1;
    end

    always @(negedge clk) begin
        if (ps_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < CH; i++) begin
            divide[i*W +: W]    = 8'(cfg_d[i]);
            high_cnt[i*W +: W]  = 8'(cfg_h[i]);
            phase_cnt[i*W +: W] = 8'(cfg_p[i]);
        end
    endtask

    task automatic set_default(input int d1, input int h1);
        cfg_d[0] = 4; cfg_h[0] = 2;
        cfg_d[1] = d1; cfg_h[1] = h1;
        cfg_d[2] = 8; cfg_h[2] = 4;
        cfg_d[3] = 2; cfg_h[3] = 1;
        cfg_d[4] = 3; cfg_h[4] = 1;
        for (int i = 0; i < CH; i++) cfg_p[i] = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1; PWRDWN = 1'b0; ps_en = 1'b0;
        apply_cfg();
        repeat (2) @(negedge clk);
        RST = 1'b0;
    endtask

    function automatic logic exp_out(input int n, input int d, input int h, input int lag);
        int c;
        c = (((n - 1 - lag) % d) + d) % d;
        return (c < h);
    endfunction

    task automatic check_wave(input string name, input int ch, input int d, input int h, input int lag);
        int nbad;
        nbad = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            if (clk_out[ch] !== exp_out(e, d, h, lag)) nbad++;
        end
        chk(name, 32'(nbad), 32'd0);
    endtask

    task automatic do_ps(input int sel, input logic inc, output int latency);
        @(negedge clk);
        ps_sel = 3'(sel); ps_incdec = inc; ps_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ps_en = 1'b0;
        latency = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (ps_done) begin
                latency = k;
                break;
            end
        end
        @(posedge clk); @(negedge clk);
        chk("ps_done_width", 32'(ps_done), 32'd0);
    endtask

    task automatic wait_lock(input string name);
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 63) chk({name, "_low63"}, 32'(lock), 32'd0);
            if (k == 64) chk({name, "_high64"}, 32'(lock), 32'd1);
        end
    endtask

    initial begin
        tbl[0]  = '{"basic_ch0",  0, 4, 2,   0, 16'b1100_1100_1100_1100};
        tbl[1]  = '{"basic_ch1",  1, 5, 1,   0, 16'b1000_0100_0010_0001};
        tbl[2]  = '{"basic_ch2",  2, 8, 4,   0, 16'b1111_0000_1111_0000};
        tbl[3]  = '{"basic_ch3",  3, 2, 1,   0, 16'b1010_1010_1010_1010};
        tbl[4]  = '{"phase3",     2, 8, 4,   3, 16'b0001_1110_0001_1110};
        tbl[5]  = '{"phase9",     2, 8, 4,   9, 16'b1110_0001_1110_0001};
        tbl[6]  = '{"high0",      2, 8, 0,   0, 16'b0000_0000_0000_0000};
        tbl[7]  = '{"high8",      2, 8, 8,   0, 16'b1111_1111_1111_1111};
        tbl[8]  = '{"divide0",    3, 0, 1,   0, 16'b1010_1010_1010_1010};
        tbl[9]  = '{"divide1",    3, 1, 1,   0, 16'b1010_1010_1010_1010};
        tbl[10] = '{"high_gt_d",  0, 4, 200, 0, 16'b1111_1111_1111_1111};

        set_default(5, 1);
        apply_cfg();
        repeat (2) @(negedge clk);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_ps_done", 32'(ps_done), 32'd0);

        foreach (tbl[i]) begin
            set_default(5, 1);
            cfg_d[tbl[i].ch] = tbl[i].d;
            cfg_h[tbl[i].ch] = tbl[i].h;
            cfg_p[tbl[i].ch] = tbl[i].p;
            do_reset();
            for (int k = 0; k < 16; k++) begin
                @(posedge clk); @(negedge clk);
                w[15-k] = clk_out[tbl[i].ch];
            end
            chk(tbl[i].name, 32'(w), 32'(tbl[i].exp));
        end

        // Lock rises on edge 64 after reset release
        set_default(8, 4);
        do_reset();
        wait_lock("lock_reset");

        // Eight increments on channel 1 walk the offset round to zero
        off_exp = 0;
        for (int r = 0; r < 8; r++) begin
            do_ps(1, 1'b1, lat);
            chk("ps_latency_inc", 32'(lat), 32'd12);
            off_exp = (off_exp + 1) % 8;
            check_wave("wave_inc", 1, 8, 4, off_exp);
        end
        chk("wrap_off_zero", 32'(off_exp), 32'd0);
        do_ps(1, 1'b0, lat);
        chk("ps_latency_dec", 32'(lat), 32'd12);
        check_wave("wave_dec_wrap", 1, 8, 4, 7);
        off_exp = 7;
        check_wave("wave_ch2_untouched", 2, 8, 4, 0);

        // Second request three cycles into the busy window is dropped
        d0 = done_cnt;
        @(negedge clk);
        ps_sel = 3'd1; ps_incdec = 1'b1; ps_en = 1'b1;
        @(posedge clk); @(negedge clk);
        ps_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ps_en = 1'b1;
        @(posedge clk); @(negedge clk);
        ps_en = 1'b0;
        repeat (30) @(negedge clk);
        chk("busy_single_done", 32'(done_cnt - d0), 32'd1);
        off_exp = (off_exp + 1) % 8;
        check_wave("busy_single_shift", 1, 8, 4, off_exp);

        // Out-of-range selects complete but change nothing
        do_ps(5, 1'b1, lat);
        chk("oor_latency", 32'(lat), 32'd12);
        do_ps(7, 1'b0, lat);
        chk("oor7_latency", 32'(lat), 32'd12);
        check_wave("oor_ch1", 1, 8, 4, off_exp);
        check_wave("oor_ch4", 4, 3, 1, 0);

        // Divide change on channel 0 drops lock and clears its offset
        do_ps(0, 1'b1, lat);
        check_wave("ch0_shift1", 0, 4, 2, 1);
        chk("lock_before_change", 32'(lock), 32'd1);
        cfg_d[0] = 6;
        apply_cfg();
        @(posedge clk); @(negedge clk);
        chk("chg_lock_fall", 32'(lock), 32'd0);
        chk("chg_ch0_low", 32'(clk_out[0]), 32'd0);
        bad = 0;
        for (int m = 1; m <= 64; m++) begin
            @(posedge clk); @(negedge clk);
            if (m <= 12 && clk_out[0] !== exp_out(m, 6, 2, 0)) bad++;
            if (m == 63) chk("chg_lock_low63", 32'(lock), 32'd0);
            if (m == 64) chk("chg_lock_high64", 32'(lock), 32'd1);
        end
        chk("chg_ch0_wave_off0", 32'(bad), 32'd0);

        // Power-down in the busy window cancels done and keeps offsets
        d0 = done_cnt;
        @(negedge clk);
        ps_sel = 3'd1; ps_incdec = 1'b1; ps_en = 1'b1;
        @(posedge clk); @(negedge clk);
        ps_en = 1'b0;
        off_exp = (off_exp + 1) % 8;
        repeat (4) @(posedge clk);
        @(negedge clk);
        PWRDWN = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("pd_clk_out", 32'(clk_out), 32'd0);
        chk("pd_lock", 32'(lock), 32'd0);
        repeat (2) @(negedge clk);
        PWRDWN = 1'b0;
        wait_lock("lock_pwrdwn");
        chk("pd_no_done", 32'(done_cnt - d0), 32'd0);
        check_wave("pd_off_kept", 1, 8, 4, off_exp);
        check_wave("pd_ch0", 0, 6, 2, 0);

        // Asynchronous reset in the busy window
        d0 = done_cnt;
        @(negedge clk);
        ps_sel = 3'd1; ps_incdec = 1'b1; ps_en = 1'b1;
        @(posedge clk); @(negedge clk);
        ps_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_clk_out", 32'(clk_out), 32'd0);
        chk("rst_mid_lock", 32'(lock), 32'd0);
        @(negedge clk);
        RST = 1'b0;
        repeat (25) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        check_wave("rst_mid_off_clear", 1, 8, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
